// File: rtl/riscv_dbg_master.sv
// Debug-port initiator: runs strobe/ack accesses, halt/resume and
// breakpoint stall for a host transport, one response per command.
module riscv_dbg_master #(
  parameter int XLEN          = 32,
  parameter int DBG_ADDR_SIZE = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DBG_ADDR_SIZE-1:0] cmd_addr,
  input  logic [XLEN-1:0]          cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_err,
  output logic                     halted,
  output logic                     bp_event,
  output logic                     dbg_stall,
  output logic                     dbg_strb,
  output logic                     dbg_we,
  output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_dati,
  input  logic [XLEN-1:0]          dbg_dato,
  input  logic                     dbg_ack,
  input  logic                     dbg_bp
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_RES = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          timeout;
  logic          accept;
  logic          is_acc;
  logic          do_halt;
  logic          do_res;

  assign accept   = (state == IDLE) && cmd_valid;
  assign is_acc   = (cmd_op == OP_RD) || (cmd_op == OP_WR);
  assign do_halt  = accept && (cmd_op == OP_HLT);
  assign do_res   = accept && (cmd_op == OP_RES);
  assign timeout  = (cnt == CW'(ACK_TIMEOUT - 1));

  assign cmd_ready = (state == IDLE);
  assign dbg_strb  = (state == REQ);
  assign rsp_valid = (state == RSP);
  assign halted    = dbg_stall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nxt = is_acc ? REQ : RSP;
      REQ:  if (dbg_ack || timeout) state_nxt = RSP;
      RSP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      dbg_we   <= 1'b0;
      dbg_addr <= '0;
      dbg_dati <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && is_acc) begin
            dbg_addr <= cmd_addr;
            dbg_dati <= cmd_data;
            dbg_we   <= (cmd_op == OP_WR);
          end else if (cmd_valid) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        end
        REQ: begin
          // saturate so a stuck counter can never wrap
          if (cnt != CW'(ACK_TIMEOUT)) cnt <= cnt + CW'(1);
          if (dbg_ack) begin
            rsp_data <= dbg_we ? '0 : dbg_dato;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RSP: if (rsp_ready) cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // a breakpoint beats a resume issued in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_stall <= 1'b0;
      bp_event  <= 1'b0;
    end else begin
      bp_event <= 1'b0;
      if (dbg_bp && (!dbg_stall || do_res)) begin
        dbg_stall <= 1'b1;
        bp_event  <= 1'b1;
      end else if (do_halt) begin
        dbg_stall <= 1'b1;
      end else if (do_res) begin
        dbg_stall <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dbg_master.sv
// Directed bench for riscv_dbg_master with a response scoreboard
// checked by an independent monitor.
module tb_riscv_dbg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        halted;
  logic        bp_event;
  logic        dbg_stall;
  logic        dbg_strb;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_dati;
  logic [31:0] dbg_dato;
  logic        dbg_ack;
  logic        dbg_bp;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  riscv_dbg_master #(
    .XLEN(32), .DBG_ADDR_SIZE(16), .ACK_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .halted(halted), .bp_event(bp_event),
    .dbg_stall(dbg_stall), .dbg_strb(dbg_strb),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_dati(dbg_dati), .dbg_dato(dbg_dato),
    .dbg_ack(dbg_ack), .dbg_bp(dbg_bp)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got %h/%b expected none",
                 rsp_data, rsp_err);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a,
                      input logic [31:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("cmd_ready_wait", 32'd0, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_ack(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      chk("strb_hold", {31'd0, dbg_strb}, 32'd1);
      step();
    end
    dbg_ack  = 1'b1;
    dbg_dato = d;
    chk("strb_at_ack", {31'd0, dbg_strb}, 32'd1);
    step();
    dbg_ack  = 1'b0;
    dbg_dato = '0;
    chk("strb_drop", {31'd0, dbg_strb}, 32'd0);
    chk("rsp_valid_ack", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = '0;
    cmd_data = '0;
    rsp_ready = 1'b1;
    dbg_dato = '0;
    dbg_ack = 1'b0;
    dbg_bp = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_stall", {31'd0, dbg_stall}, 32'd0);
    chk("rst_strb", {31'd0, dbg_strb}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_bp_event", {31'd0, bp_event}, 32'd0);

    // halt
    sb.push_back({1'b0, 32'h0});
    send(2'b10, 16'h0, 32'h0);
    chk("halt_stall", {31'd0, dbg_stall}, 32'd1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    step();

    // write CTRL
    sb.push_back({1'b0, 32'h0});
    send(2'b01, 16'h0000, 32'h3);
    chk("wr_we", {31'd0, dbg_we}, 32'd1);
    chk("wr_dati", dbg_dati, 32'h3);
    chk("wr_addr", {16'd0, dbg_addr}, 32'h0);
    do_ack(2, 32'h5555_AAAA);
    step();

    // back-to-back GPR reads
    sb.push_back({1'b0, 32'hDEADBEEF});
    send(2'b00, 16'h1005, 32'h0);
    chk("rd_we", {31'd0, dbg_we}, 32'd0);
    chk("rd_addr", {16'd0, dbg_addr}, 32'h1005);
    do_ack(0, 32'hDEADBEEF);
    sb.push_back({1'b0, 32'h12345678});
    send(2'b00, 16'h1006, 32'h0);
    chk("rd2_addr", {16'd0, dbg_addr}, 32'h1006);
    do_ack(1, 32'h12345678);
    step();

    // resume, then CSR read times out
    sb.push_back({1'b0, 32'h0});
    send(2'b11, 16'h0, 32'h0);
    chk("res_stall", {31'd0, dbg_stall}, 32'd0);
    step();
    sb.push_back({1'b1, 32'h0});
    send(2'b00, 16'h2000, 32'h0);
    n = 0;
    while (dbg_strb && n < 1000) begin
      n++;
      step();
    end
    chk("timeout_len", n, 32'd255);
    chk("timeout_strb", {31'd0, dbg_strb}, 32'd0);
    chk("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    step();

    // breakpoints
    dbg_bp = 1'b1;
    step();
    dbg_bp = 1'b0;
    chk("bp_stall", {31'd0, dbg_stall}, 32'd1);
    chk("bp_event", {31'd0, bp_event}, 32'd1);
    step();
    chk("bp_event_1cyc", {31'd0, bp_event}, 32'd0);
    dbg_bp = 1'b1;
    step();
    dbg_bp = 1'b0;
    chk("bp2_no_event", {31'd0, bp_event}, 32'd0);
    chk("bp2_stall", {31'd0, dbg_stall}, 32'd1);
    sb.push_back({1'b0, 32'h0});
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    dbg_bp = 1'b1;
    step();
    cmd_valid = 1'b0;
    dbg_bp = 1'b0;
    chk("bp_res_stall", {31'd0, dbg_stall}, 32'd1);
    chk("bp_res_event", {31'd0, bp_event}, 32'd1);
    chk("bp_res_rsp", {31'd0, rsp_valid}, 32'd1);
    step();

    // reset mid-access, response discarded
    rsp_ready = 1'b0;
    send(2'b00, 16'h2004, 32'h0);
    step();
    chk("pre_rst_strb", {31'd0, dbg_strb}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_strb", {31'd0, dbg_strb}, 32'd0);
    chk("mid_rst_stall", {31'd0, dbg_stall}, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;

    // access after reset still works; write returns 0
    sb.push_back({1'b0, 32'h0});
    send(2'b01, 16'h0004, 32'hA5);
    do_ack(0, 32'h77);
    step();
    step();
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
